shift_seq_ctrl: RTL
===================

# shift_seq_ctrl

Controller that sequences a serial-out shift datapath: accepts a parallel word over a valid/ready handshake, then drives it out one bit per clock, MSB first, with a shift-enable strobe and framing flags. It sits between a parallel producer and any SISO-style serial consumer, and owns load/shift/idle sequencing so the consumer sees a clean, gapped bit stream. An optional parity bit follows each word.

## Interface
Parameters:
- WIDTH, 4: data word width in bits, at least 2.
- GAP, 1: idle cycles inserted after each word before the next is accepted, 0 to 15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  controller can accept a word this cycle.
- serial_out  output  1  current serial bit, registered.
- shift_en  output  1  high in every cycle where serial_out carries a valid bit.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse in the cycle carrying the last bit of a word.

## Operation
- States: IDLE, SHIFT, PAR (present only with the macro), GAPW.
- IDLE:
  - din_ready=1.
  - On din_valid && din_ready at a rising edge, capture din into the internal shift register, set the bit counter to WIDTH-1, and go to SHIFT.
- SHIFT:
  - serial_out = shift_reg[WIDTH-1] and shift_en=1.
  - Each cycle, shift the register left by one and fill with 0.
  - When counter = 0, go to PAR if enabled. Otherwise go to GAPW, or to IDLE when GAP=0.
  - Decrement the counter otherwise.
- PAR: serial_out = XOR of the captured word (even parity), shift_en=1, then go to GAPW, or to IDLE when GAP=0.
- GAPW: serial_out=0, shift_en=0, din_ready=0. Count GAP cycles, then go to IDLE.
- Outside SHIFT/PAR: serial_out=0 and shift_en=0.
- din_ready is 0 in every state except IDLE. din_valid and din are ignored while busy; there is no queuing.
- din_valid may drop without an accept; no state change results.
- Outputs are registered from state. din_ready is combinational from state (state==IDLE && !rst is not required, since the state is IDLE after reset).

## Timing
- Reset values: state IDLE, shift register 0, counters 0, serial_out=0, shift_en=0, busy=0, done=0. din_ready=1 in the first cycle after rst deasserts. While rst=1, din_ready reads 1 only through IDLE decode; any handshake in a reset cycle is discarded.
- Latency: the first bit (din[WIDTH-1]) appears on serial_out in the cycle immediately after the accepting edge.
- Bit timing: bit k (MSB = bit 0 of the stream) appears k cycles later.
- done is high in the same cycle as the final data bit, or in the same cycle as the parity bit when the macro is enabled.
- Word period in cycles, accept edge to next possible accept edge: WIDTH + P + GAP + 1, where P is 1 with parity and 0 without.
- Reset mid-word: at the next edge, return to IDLE with all outputs at reset values. The partial word is dropped; no done pulse occurs.
- With GAP=0, din_ready returns to 1 in the cycle after the last bit.

## Configuration
- SHIFT_PARITY_EN defined:
  - PAR state exists.
  - One even-parity bit follows each word with shift_en=1.
  - done moves to the parity cycle.
- Not defined:
  - PAR state is absent.
  - done is on the last data bit.
  - Period shrinks by one cycle.

## Test plan
- Basic word: WIDTH=4, GAP=1, no macro. Accept din=4'b1011. Required response:
  - serial_out = 1,0,1,1 on cycles +1..+4, with shift_en=1.
  - done only on +4.
  - din_ready=0 on +1..+5 and 1 again on +6.
- Parity: with SHIFT_PARITY_EN, send din=4'b1011. Required response:
  - Bits 1,0,1,1, then parity 1 on +5, with done on +5.
  - Send din=4'b0110: parity bit 0.
- Valid while busy: hold din_valid=1 throughout with din changing each cycle. Required response:
  - Only the word present at each IDLE accept is serialized.
  - Period is exactly WIDTH+P+GAP+1 cycles.
- Reset mid-word: assert rst for one cycle on +2 of a 4'b1111 word. Required response:
  - Next cycle: serial_out=0, shift_en=0, busy=0, no done, din_ready=1.
- GAP=0 back-to-back: send 4'b1000 then 4'b0001. Required response:
  - Stream 1,0,0,0, then one idle cycle (accept), then 0,0,0,1.
  - Two done pulses, 5 cycles apart.
- Post-reset: hold rst=1 for 3 cycles with din_valid=1. Required response:
  - No shift_en during reset.
  - First bit appears 2 cycles after rst falls.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serializes a parallel word MSB first behind a valid/ready
// handshake, with a shift-enable strobe, a done pulse on the final bit and a
// programmable idle gap between words.
//
// Optional feature macro: SHIFT_PARITY_EN
//   When defined, an even-parity bit follows each word, and done moves to the
//   parity cycle.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   GAP        idle cycles after each word before the next accept (0..15)
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   din        parallel word to serialize
//   din_valid  producer has a word on din
//   din_ready  controller accepts a word this cycle (decoded from state)
//   serial_out current serial bit (registered)
//   shift_en   serial_out carries a valid bit (registered)
//   busy       controller is not idle (registered)
//   done       pulse in the cycle carrying the last bit of a word (registered)
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned GW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  // Gap counter runs GAP-1 down to 0; unused when GAP is 0.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP == 0) ? 0 : (GAP - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SHIFT_PARITY_EN
    PAR   = 2'd2,
`endif
    GAPW  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_reg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             serial_out_n, shift_en_n, busy_n, done_n;
  state_t           after_word;
`ifdef SHIFT_PARITY_EN
  logic             par, par_n;
`endif

  // Ready is a pure state decode so the producer sees it in the same cycle.
  assign din_ready = (state == IDLE);

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_n      = state;
    shift_reg_n  = shift_reg;
    cnt_n        = cnt;
    gcnt_n       = gcnt;
    serial_out_n = 1'b0;
    shift_en_n   = 1'b0;
    done_n       = 1'b0;
`ifdef SHIFT_PARITY_EN
    par_n        = par;
`endif
    after_word   = (GAP == 0) ? IDLE : GAPW;

    case (state)
      IDLE: begin
        if (din_valid) begin
          shift_reg_n  = din;
          cnt_n        = CNT_LAST;
          state_n      = SHIFT;
          serial_out_n = din[WIDTH-1];
          shift_en_n   = 1'b1;
`ifdef SHIFT_PARITY_EN
          par_n        = ^din;
`endif
        end
      end

      SHIFT: begin
        shift_reg_n = shift_reg << 1;
        if (cnt == '0) begin
`ifdef SHIFT_PARITY_EN
          state_n      = PAR;
          serial_out_n = par;
          shift_en_n   = 1'b1;
          done_n       = 1'b1;
`else
          state_n      = after_word;
          gcnt_n       = GAP_LAST;
`endif
        end else begin
          cnt_n        = cnt - CW'(1);
          serial_out_n = shift_reg_n[WIDTH-1];
          shift_en_n   = 1'b1;
`ifndef SHIFT_PARITY_EN
          // The bit going out next cycle is the last one when cnt reaches 0.
          done_n       = (cnt == CW'(1));
`endif
        end
      end

`ifdef SHIFT_PARITY_EN
      PAR: begin
        state_n = after_word;
        gcnt_n  = GAP_LAST;
      end
`endif

      GAPW: begin
        if (gcnt == '0) begin
          state_n = IDLE;
        end else begin
          gcnt_n = gcnt - GW'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      serial_out <= 1'b0;
      shift_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SHIFT_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shift_reg  <= shift_reg_n;
      cnt        <= cnt_n;
      gcnt       <= gcnt_n;
      serial_out <= serial_out_n;
      shift_en   <= shift_en_n;
      busy       <= busy_n;
      done       <= done_n;
`ifdef SHIFT_PARITY_EN
      par        <= par_n;
`endif
    end
  end

endmodule
